// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared constants and state type for the nibble-serial adder
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - req/ready/valid bus of the nibble-serial adder
// Optional sub_i signal exists only when NIBBLE_ADDER_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             req_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
`ifdef NIBBLE_ADDER_SUB_EN
  logic             sub_i;
`endif
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;

`ifdef NIBBLE_ADDER_SUB_EN
  modport master (
    output req_i, a_i, b_i, carry_i, sub_i,
    input  ready_o, valid_o, sum_o, carry_o
  );

  modport slave (
    input  req_i, a_i, b_i, carry_i, sub_i,
    output ready_o, valid_o, sum_o, carry_o
  );
`else
  modport master (
    output req_i, a_i, b_i, carry_i,
    input  ready_o, valid_o, sum_o, carry_o
  );

  modport slave (
    input  req_i, a_i, b_i, carry_i,
    output ready_o, valid_o, sum_o, carry_o
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// rtl/nibble_serial_adder_ctrl_cla.sv - 4-bit carry-lookahead adder used as the shared datapath
module cla_four_fulladder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // All carries derived directly from carry_i; no ripple between bit positions.
  assign w_c[0] = carry_i;
  assign w_c[1] = w_g[0] | (w_p[0] & carry_i);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & carry_i);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & carry_i);
  assign carry_o = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & carry_i);

  assign sum_o = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequencing one 4-bit CLA, LSB nibble first
// Define NIBBLE_ADDER_SUB_EN to add the sub_i port (A-B via ~B and forced carry-in).
module nibble_serial_adder_ctrl
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_BUSY = 2'(BUSY);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry_out;
  logic                r_valid;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic                w_cout;
  logic [WIDTH-1:0]    w_b_load;
  logic                w_carry_load;

  assign w_a_nib = r_a[NIBBLE_W*r_cnt +: NIBBLE_W];
  assign w_b_nib = r_b[NIBBLE_W*r_cnt +: NIBBLE_W];

`ifdef NIBBLE_ADDER_SUB_EN
  assign w_b_load     = bus.sub_i ? ~bus.b_i : bus.b_i;
  assign w_carry_load = bus.sub_i | bus.carry_i;
`else
  assign w_b_load     = bus.b_i;
  assign w_carry_load = bus.carry_i;
`endif

  cla_four_fulladder u_cla (
    .a_i     (w_a_nib),
    .b_i     (w_b_nib),
    .carry_i (r_carry),
    .sum_o   (w_sum_nib),
    .carry_o (w_cout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_i) begin
            r_a     <= bus.a_i;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_sum[NIBBLE_W*r_cnt +: NIBBLE_W] <= w_sum_nib;
          r_carry <= w_cout;
          if (r_cnt == LAST_CNT) begin
            // Counter parks at zero so it never runs past the last nibble.
            r_cnt       <= '0;
            r_carry_out <= w_cout;
            r_valid     <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o = (r_state == ST_IDLE);
  assign bus.valid_o = r_valid;
  assign bus.sum_o   = r_sum;
  assign bus.carry_o = r_carry_out;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for the nibble-serial adder
// Optional subtraction vectors run when NIBBLE_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int W       = 32;
  localparam int NIBBLES = W / 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cy;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_seen = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  int   acc_hist[$];

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s, int at);
    exp_t e;
    logic [W:0] t;
    if (s) begin
      t[W-1:0] = a - b;
      t[W]     = (a >= b);
    end else begin
      t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    end
    e.sum = t[W-1:0];
    e.cy  = t[W];
    e.cyc = at;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (bound expired) t=%0t", name, $time);
  endtask

  // Input-side observer: record each accepted request and its expected result.
  always @(posedge clk) begin
    logic s;
    cyc++;
    s = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
    s = bus.sub_i;
`endif
    if (!rst && bus.req_i && bus.ready_o) begin
      sb.push_back(model(bus.a_i, bus.b_i, bus.carry_i, s, cyc));
      acc_hist.push_back(cyc);
    end
  end

  // Output-side monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o) begin
        valid_seen++;
        chk("valid_single_cycle", {63'd0, prev_valid}, 64'd0);
        chk("ready_low_in_done", {63'd0, bus.ready_o}, 64'd0);
        if (sb.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          e = sb.pop_front();
          chk("sum", {32'd0, bus.sum_o}, {32'd0, e.sum});
          chk("carry", {63'd0, bus.carry_o}, {63'd0, e.cy});
          chk("latency", 64'(cyc - e.cyc), 64'(NIBBLES));
        end
      end
      prev_valid = bus.valid_o;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) fail_now("wait_ready");
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    wait_ready();
    bus.a_i     = a;
    bus.b_i     = b;
    bus.carry_i = c;
`ifdef NIBBLE_ADDER_SUB_EN
    bus.sub_i   = s;
`else
    if (s) $display("note: sub vector skipped in add-only build");
`endif
    bus.req_i = 1'b1;
    @(negedge clk);
    bus.req_i   = 1'b0;
    bus.a_i     = '1;
    bus.b_i     = $urandom;
    bus.carry_i = ~c;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
    @(negedge clk);
  endtask

  initial begin
    int n;
    int vcount;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.req_i   = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.carry_i = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
    bus.sub_i   = 1'b0;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("rst_sum", {32'd0, bus.sum_o}, 64'd0);
    chk("rst_carry", {63'd0, bus.carry_o}, 64'd0);

    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    drain();
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drain();
    issue(32'h00000000, 32'h00000000, 1'b1, 1'b0);
    drain();

    // Back-to-back with req held high.
    wait_ready();
    bus.a_i = 32'hDEADBEEF; bus.b_i = 32'h01020304; bus.carry_i = 1'b1;
    bus.req_i = 1'b1;
    @(negedge clk);
    bus.a_i = 32'h80000000; bus.b_i = 32'h80000000; bus.carry_i = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      chk("b2b_ready_low", {63'd0, bus.ready_o}, 64'd0);
      if (bus.valid_o) break;
      n++;
    end
    if (n >= 40) fail_now("b2b_valid");
    @(negedge clk);
    chk("b2b_ready_idle", {63'd0, bus.ready_o}, 64'd1);
    @(negedge clk);
    bus.req_i = 1'b0;
    chk("b2b_accepts", 64'(acc_hist.size()), 64'd5);
    if (acc_hist.size() >= 2)
      chk("b2b_spacing", 64'(acc_hist[$] - acc_hist[$-1]), 64'(NIBBLES + 2));
    drain();

    // Asynchronous reset in the middle of BUSY (cnt == 3).
    wait_ready();
    bus.a_i = 32'h12345678; bus.b_i = 32'h11111111; bus.carry_i = 1'b0;
    bus.req_i = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    bus.req_i = 1'b0;
    chk("pre_rst_busy", {63'd0, bus.ready_o}, 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", {32'd0, bus.sum_o}, 64'd0);
    chk("mid_rst_carry", {63'd0, bus.carry_o}, 64'd0);
    chk("mid_rst_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.ready_o}, 64'd1);
    sb.delete();
    vcount = valid_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (NIBBLES + 4) @(negedge clk);
    chk("post_rst_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("post_rst_no_valid", 64'(valid_seen - vcount), 64'd0);
    issue(32'hCAFEF00D, 32'h35010FF3, 1'b1, 1'b0);
    drain();

`ifdef NIBBLE_ADDER_SUB_EN
    issue(32'd5, 32'd7, 1'b0, 1'b1);
    drain();
    issue(32'd7, 32'd5, 1'b0, 1'b1);
    drain();
`endif

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) ra = '1;
      if (i % 16 == 1) rb = '1;
      issue(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog (simulation time limit)");
    $fatal(1, "watchdog");
  end

endmodule
